filter_tx: RTL

FILTER_TX -- requirements
Module: filter_tx

---
 rtl/filter_tx.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/filter_tx.sv
// filter_tx: serial line transmitter for the sig_in filter.
// Each frame is a START symbol (line 1), DATA_W payload bits sent MSB first,
// and a STOP symbol (line 0). Every symbol is held HOLD clock cycles.
// Optionally, the first cycle of every payload bit period is inverted so that
// the downstream glitch filter can be exercised. START/STOP are never glitched,
// and glitching is suppressed when HOLD=3 because too few correct cycles would
// remain in each bit period.
//
// All outputs are registers. They are loaded from the decoded line level of the
// next state, so the line rises on the same edge that accepts the word.
module filter_tx #(
    parameter int HOLD   = 4,   // cycles per line symbol, legal range 3..15
    parameter int DATA_W = 8    // payload bits per frame
) (
    input  logic              clock,
    input  logic              reset,      // asynchronous, active-low
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              glitch_en,
    output logic              sig_out,
    output logic              busy
);

    localparam int CW = (HOLD > 2) ? $clog2(HOLD) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(HOLD - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    // With HOLD=3 a glitch would leave only two correct cycles per bit.
    localparam logic          GLITCH_OK = (HOLD >= 4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     cyc_cnt;
    logic [CW-1:0]     cyc_cnt_next;
    logic [BW-1:0]     bit_cnt;
    logic [BW-1:0]     bit_cnt_next;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_next;
    logic              glitch_q;
    logic              glitch_next;

    logic              handshake;
    logic              sym_done;
    logic [BW-1:0]     bit_idx;
    logic              data_bit;
    logic              glitch_now;
    logic              sig_next;
    logic              busy_next;
    logic              ready_next;

    // tx_ready is only ever high in IDLE, so this is the IDLE handshake.
    assign handshake = tx_valid & tx_ready;
    // Last cycle of the current line symbol.
    assign sym_done  = (cyc_cnt == CNT_LAST);

    // State register: FSM state, symbol/bit counters and the captured word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cyc_cnt  <= '0;
            bit_cnt  <= '0;
            data_q   <= '0;
            glitch_q <= 1'b0;
        end else begin
            state    <= state_next;
            cyc_cnt  <= cyc_cnt_next;
            bit_cnt  <= bit_cnt_next;
            data_q   <= data_next;
            glitch_q <= glitch_next;
        end
    end

    // Next-state logic: counters restart at 0 on the same edge as every
    // state change, so each symbol is exactly HOLD cycles long.
    always_comb begin
        state_next   = state;
        cyc_cnt_next = cyc_cnt + 1'b1;
        bit_cnt_next = bit_cnt;
        data_next    = data_q;
        glitch_next  = glitch_q;

        case (state)
            IDLE: begin
                cyc_cnt_next = '0;
                bit_cnt_next = '0;
                if (handshake) begin
                    state_next  = START;
                    data_next   = tx_data;
                    glitch_next = glitch_en;
                end
            end

            START: begin
                if (sym_done) begin
                    state_next   = DATA;
                    cyc_cnt_next = '0;
                    bit_cnt_next = '0;
                end
            end

            DATA: begin
                if (sym_done) begin
                    cyc_cnt_next = '0;
                    if (bit_cnt == BIT_LAST) begin
                        state_next   = STOP;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end

            STOP: begin
                if (sym_done) begin
                    state_next   = IDLE;
                    cyc_cnt_next = '0;
                end
            end

            default: begin
                state_next   = IDLE;
                cyc_cnt_next = '0;
                bit_cnt_next = '0;
            end
        endcase
    end

    // Output decode of the next state: line level, busy and ready values
    // that the output registers take on the coming edge.
    always_comb begin
        bit_idx    = BIT_LAST - bit_cnt_next;
        data_bit   = data_q[bit_idx];
        glitch_now = glitch_q & GLITCH_OK & (cyc_cnt_next == '0);
        sig_next   = 1'b0;
        busy_next  = 1'b1;
        ready_next = 1'b0;

        case (state_next)
            IDLE: begin
                sig_next   = 1'b0;
                busy_next  = 1'b0;
                ready_next = 1'b1;
            end
            START:   sig_next = 1'b1;
            DATA:    sig_next = data_bit ^ glitch_now;
            STOP:    sig_next = 1'b0;
            default: sig_next = 1'b0;
        endcase
    end

    // Output registers. tx_ready resets low and rises on the first edge
    // after reset is released, so no word can be taken during reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sig_out  <= 1'b0;
            busy     <= 1'b0;
            tx_ready <= 1'b0;
        end else begin
            sig_out  <= sig_next;
            busy     <= busy_next;
            tx_ready <= ready_next;
        end
    end

endmodule
